instr_fetch: RTL and testbench

- Upstream front-end stage for the 10-instruction processor.
- Fetches 32-bit instruction words from a synchronous instruction memory using a program counter (PC).
- Splits each word into the processor's Opcode/DstOp/SrcOp/srcIsImm inputs and presents them through a valid/ready handshake.
- Accepts branch redirects from the execute stage and stops permanently after delivering HLT.

---
 rtl/proc_pkg.sv | 33 +++
 rtl/instr_decode.sv | 40 ++++
 rtl/instr_fetch.sv | 129 ++++++++++++
 tb/tb_instr_fetch.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the 10-instruction processor: opcodes, instruction
// word field positions and the fetch-stage state encoding.
package proc_pkg;

    localparam logic [3:0] NOP = 4'h0;
    localparam logic [3:0] LD  = 4'h1;
    localparam logic [3:0] STR = 4'h2;
    localparam logic [3:0] BRA = 4'h3;
    localparam logic [3:0] XOR = 4'h4;
    localparam logic [3:0] ADD = 4'h5;
    localparam logic [3:0] ROT = 4'h6;
    localparam logic [3:0] SHF = 4'h7;
    localparam logic [3:0] HLT = 4'h8;
    localparam logic [3:0] CMP = 4'h9;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int IMM_BIT = 27;
    localparam int CC_MSB  = 26;
    localparam int CC_LSB  = 24;
    localparam int SRC_MSB = 23;
    localparam int SRC_LSB = 12;
    localparam int DST_MSB = 11;
    localparam int DST_LSB = 0;

    typedef enum logic [1:0] {FETCH, WAIT, HOLD, HALT} fetch_state_e;

    // Anything above CMP is not part of the instruction set.
    function automatic logic is_illegal(input logic [3:0] op);
        return op > CMP;
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational split of a 32-bit instruction word into processor fields.
// INSTR_FETCH_ILLEGAL_OP_EN turns unknown opcodes into a flagged NOP.
module instr_decode
    import proc_pkg::*;
#(
    parameter int BUSW = 32
) (
    input  logic [31:0]     word,
    output logic [3:0]      Opcode,
    output logic            srcIsImm,
    output logic [BUSW-1:0] SrcOp,
    output logic [BUSW-1:0] DstOp
`ifdef INSTR_FETCH_ILLEGAL_OP_EN
    ,
    output logic            illegal
`endif
);

    always_comb begin
        Opcode   = word[OP_MSB:OP_LSB];
        srcIsImm = word[IMM_BIT];
        SrcOp    = BUSW'(word[SRC_MSB:SRC_LSB]);
        DstOp    = BUSW'(word[DST_MSB:DST_LSB]);
        // A branch carries its condition code where other ops carry a source.
        if (word[OP_MSB:OP_LSB] == BRA) begin
            SrcOp    = BUSW'(word[CC_MSB:CC_LSB]);
            srcIsImm = 1'b0;
        end
`ifdef INSTR_FETCH_ILLEGAL_OP_EN
        illegal = is_illegal(word[OP_MSB:OP_LSB]);
        if (illegal) begin
            Opcode   = NOP;
            srcIsImm = 1'b0;
            SrcOp    = '0;
            DstOp    = '0;
        end
`endif
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, synchronous imem read, decode and valid/ready
// delivery with branch redirect and halt. Optional: INSTR_FETCH_ILLEGAL_OP_EN.
module instr_fetch
    import proc_pkg::*;
#(
    parameter int            BUSW     = 32,
    parameter int            AW       = 12,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int            CNTW     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            ImemRen,
    output logic [AW-1:0]   ImemAddr,
    input  logic [31:0]     ImemData,
    output logic [3:0]      Opcode,
    output logic            srcIsImm,
    output logic [BUSW-1:0] SrcOp,
    output logic [BUSW-1:0] DstOp,
    output logic            instValid,
    input  logic            instReady,
    input  logic            BraTaken,
    input  logic [AW-1:0]   BraTarget,
    output logic [AW-1:0]   Pc,
    output logic            Halted,
    output logic [CNTW-1:0] InstCount,
    output logic [1:0]      DbgState
`ifdef INSTR_FETCH_ILLEGAL_OP_EN
    ,
    output logic            IllegalOp,
    output logic [AW-1:0]   IllegalPc
`endif
);

    // Handshake: an instruction transfers on any clk edge where instValid and
    // instReady are both high; fields stay stable while instValid waits.

    fetch_state_e state_q, state_d;

    logic [3:0]      dec_op;
    logic            dec_imm;
    logic [BUSW-1:0] dec_src;
    logic [BUSW-1:0] dec_dst;
    logic            accept;
    logic            redirect;
`ifdef INSTR_FETCH_ILLEGAL_OP_EN
    logic            dec_illegal;
`endif

    instr_decode #(.BUSW(BUSW)) u_decode (
        .word     (ImemData),
        .Opcode   (dec_op),
        .srcIsImm (dec_imm),
        .SrcOp    (dec_src),
        .DstOp    (dec_dst)
`ifdef INSTR_FETCH_ILLEGAL_OP_EN
        ,
        .illegal  (dec_illegal)
`endif
    );

    assign accept   = instValid & instReady;
    assign redirect = BraTaken & (state_q != HALT);
    assign ImemAddr = Pc;
    assign DbgState = state_q;

    always_comb begin
        state_d = state_q;
        ImemRen = 1'b0;
        unique case (state_q)
            FETCH: begin
                ImemRen = 1'b1;
                state_d = WAIT;
            end
            WAIT: state_d = HOLD;
            HOLD: if (accept) state_d = (Opcode == HLT) ? HALT : FETCH;
            HALT: state_d = HALT;
        endcase
        if (redirect) state_d = FETCH;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            Pc        <= RESET_PC;
            Opcode    <= NOP;
            srcIsImm  <= 1'b0;
            SrcOp     <= '0;
            DstOp     <= '0;
            instValid <= 1'b0;
            Halted    <= 1'b0;
            InstCount <= '0;
`ifdef INSTR_FETCH_ILLEGAL_OP_EN
            IllegalOp <= 1'b0;
            IllegalPc <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (accept && (InstCount != '1)) InstCount <= InstCount + CNTW'(1);
            // A redirect during WAIT drops the word being returned.
            if (state_q == WAIT && !redirect) begin
                Opcode    <= dec_op;
                srcIsImm  <= dec_imm;
                SrcOp     <= dec_src;
                DstOp     <= dec_dst;
                instValid <= 1'b1;
`ifdef INSTR_FETCH_ILLEGAL_OP_EN
                if (dec_illegal && !IllegalOp) begin
                    IllegalOp <= 1'b1;
                    IllegalPc <= Pc;
                end
`endif
            end
            if (accept) begin
                instValid <= 1'b0;
                if (!redirect) begin
                    if (Opcode == HLT) Halted <= 1'b1;
                    else               Pc     <= Pc + AW'(1);
                end
            end
            // Redirect wins over everything, including an accepted HLT.
            if (redirect) begin
                Pc        <= BraTarget;
                instValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed steps plus a randomized stretch checked
// against a transaction-level model of PC, count and delivery timing.
module tb_instr_fetch;

    localparam int BUSW = 32;
    localparam int AW   = 12;
    localparam int CNTW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ImemRen;
    logic [AW-1:0]   ImemAddr;
    logic [31:0]     imem_data = '0;
    logic [3:0]      Opcode;
    logic            srcIsImm;
    logic [BUSW-1:0] SrcOp;
    logic [BUSW-1:0] DstOp;
    logic            instValid;
    logic            instReady = 1'b0;
    logic            BraTaken = 1'b0;
    logic [AW-1:0]   BraTarget = '0;
    logic [AW-1:0]   Pc;
    logic            Halted;
    logic [CNTW-1:0] InstCount;
    logic [1:0]      DbgState;
`ifdef INSTR_FETCH_ILLEGAL_OP_EN
    logic            IllegalOp;
    logic [AW-1:0]   IllegalPc;
`endif

    instr_fetch #(.BUSW(BUSW), .AW(AW), .RESET_PC('0), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ImemRen   (ImemRen),
        .ImemAddr  (ImemAddr),
        .ImemData  (imem_data),
        .Opcode    (Opcode),
        .srcIsImm  (srcIsImm),
        .SrcOp     (SrcOp),
        .DstOp     (DstOp),
        .instValid (instValid),
        .instReady (instReady),
        .BraTaken  (BraTaken),
        .BraTarget (BraTarget),
        .Pc        (Pc),
        .Halted    (Halted),
        .InstCount (InstCount),
        .DbgState  (DbgState)
`ifdef INSTR_FETCH_ILLEGAL_OP_EN
        ,
        .IllegalOp (IllegalOp),
        .IllegalPc (IllegalPc)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    // synchronous instruction memory: data one cycle after the read enable
    logic [31:0] mem [0:4095];
    always @(posedge clk) if (ImemRen) imem_data <= mem[ImemAddr];

    int tests = 0;
    int fails = 0;
    logic [AW-1:0]   ref_pc;
    logic [CNTW-1:0] ref_cnt;
    int gap;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // reference decode, straight from the field rules
    task automatic exp_decode(input logic [31:0] w, output logic [3:0] op, output logic imm,
                              output logic [31:0] src, output logic [31:0] dst);
        op  = 4'(w >> 28);
        dst = w & 32'hFFF;
        if (op == 4'd3) begin
            src = (w >> 24) & 32'h7;
            imm = 1'b0;
        end else begin
            src = (w >> 12) & 32'hFFF;
            imm = w[27];
        end
`ifdef INSTR_FETCH_ILLEGAL_OP_EN
        if (op >= 4'hA) begin
            op = 4'h0; imm = 1'b0; src = '0; dst = '0;
        end
`endif
    endtask

    task automatic check_fields(input string tag, input logic [31:0] w);
        logic [3:0]  e_op;
        logic        e_imm;
        logic [31:0] e_src, e_dst;
        exp_decode(w, e_op, e_imm, e_src, e_dst);
        check({tag, "_op"},  32'(Opcode),   32'(e_op));
        check({tag, "_imm"}, 32'(srcIsImm), 32'(e_imm));
        check({tag, "_src"}, SrcOp,         e_src);
        check({tag, "_dst"}, DstOp,         e_dst);
    endtask

    task automatic wait_valid(input string tag, input int bound);
        int n = 0;
        while (!instValid && n < bound) begin
            tick();
            n++;
        end
        check({tag, "_valid_timeout"}, 32'(instValid), 32'd1);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        logic [3:0]  op;
        op = 4'($urandom_range(0, 8));
        if (op == 4'd8) op = 4'd9;
        w = $urandom();
        w[31:28] = op;
        return w;
    endfunction

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = rand_word();
        mem[0]      = 32'h5800_A003;
        mem[1]      = 32'h3500_0020;
        mem[7]      = 32'hC012_3456;
        mem[12'hFFF] = 32'h0000_0000;
        mem[12'hF00] = 32'h8000_0000;
        mem[12'hF80] = 32'h8ABC_DEF0;

        // reset values
        tick(); tick();
        check("rst_valid", 32'(instValid), 32'd0);
        check("rst_pc",    32'(Pc),        32'd0);
        check("rst_halt",  32'(Halted),    32'd0);
        check("rst_cnt",   32'(InstCount), 32'd0);
        check("rst_op",    32'(Opcode),    32'd0);
        check("rst_imm",   32'(srcIsImm),  32'd0);
        check("rst_src",   SrcOp,          32'd0);
        check("rst_dst",   DstOp,          32'd0);
`ifdef INSTR_FETCH_ILLEGAL_OP_EN
        check("rst_illegal", 32'(IllegalOp), 32'd0);
`endif

        // first fetch: read at cycle 0, valid at cycle 2
        rst_n = 1'b1;
        check("c0_ren",  32'(ImemRen),  32'd1);
        check("c0_addr", 32'(ImemAddr), 32'd0);
        tick();
        check("c1_ren",   32'(ImemRen),   32'd0);
        check("c1_valid", 32'(instValid), 32'd0);
        tick();
        check("c2_valid", 32'(instValid), 32'd1);
        check_fields("add", mem[0]);

        // stall: fields stay put
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", 32'(instValid), 32'd1);
            check_fields("stall", mem[0]);
            check("stall_pc",  32'(Pc),        32'd0);
            check("stall_cnt", 32'(InstCount), 32'd0);
        end
        instReady = 1'b1;
        tick();
        instReady = 1'b0;
        check("acc0_valid", 32'(instValid), 32'd0);
        check("acc0_pc",    32'(Pc),        32'd1);
        check("acc0_cnt",   32'(InstCount), 32'd1);
        check("acc0_ren",   32'(ImemRen),   32'd1);
        check("acc0_addr",  32'(ImemAddr),  32'd1);

        // BRA decode
        tick(); tick();
        check("bra_valid", 32'(instValid), 32'd1);
        check_fields("bra", mem[1]);
        instReady = 1'b1;
        tick();
        instReady = 1'b0;
        check("acc1_pc",  32'(Pc),        32'd2);
        check("acc1_cnt", 32'(InstCount), 32'd2);

        // redirect during WAIT discards the in-flight word
        tick();
        check("wait_ren", 32'(ImemRen), 32'd0);
        BraTaken = 1'b1; BraTarget = 12'h040;
        tick();
        BraTaken = 1'b0;
        check("redir_pc",    32'(Pc),        32'h40);
        check("redir_addr",  32'(ImemAddr),  32'h40);
        check("redir_ren",   32'(ImemRen),   32'd1);
        check("redir_valid", 32'(instValid), 32'd0);
        tick();
        check("redir_wait_valid", 32'(instValid), 32'd0);
        tick();
        check("redir_hold_valid", 32'(instValid), 32'd1);
        check_fields("redir", mem[12'h040]);
        instReady = 1'b1;
        tick();
        instReady = 1'b0;
        check("acc2_pc",  32'(Pc),        32'h41);
        check("acc2_cnt", 32'(InstCount), 32'd3);

        // randomized stretch against the transaction model
        ref_pc = 12'h041;
        ref_cnt = 16'd3;
        gap = 0;
        for (int cyc = 0; cyc < 450; cyc++) begin
            logic acc, bra;
            logic [AW-1:0] tgt;
            check("rnd_valid", 32'(instValid), 32'(gap >= 2));
            check("rnd_ren",   32'(ImemRen),   32'(gap == 0));
            if (gap == 0) check("rnd_addr", 32'(ImemAddr), 32'(ref_pc));
            if (gap >= 2) check_fields("rnd", mem[ref_pc]);
            instReady = ($urandom_range(0, 3) != 0);
            bra = ($urandom_range(0, 15) == 0);
            tgt = AW'($urandom_range(12'h300, 12'hE00));
            BraTaken = bra;
            BraTarget = tgt;
            acc = (gap >= 2) && instReady;
            if (acc && ref_cnt != '1) ref_cnt = ref_cnt + 1'b1;
            if (bra)      ref_pc = tgt;
            else if (acc) ref_pc = ref_pc + 1'b1;
            gap = (bra || acc) ? 0 : gap + 1;
            tick();
            check("rnd_pc",  32'(Pc),        32'(ref_pc));
            check("rnd_cnt", 32'(InstCount), 32'(ref_cnt));
        end
        instReady = 1'b0;
        BraTaken = 1'b0;

        // PC wrap at the top of the address space
        BraTaken = 1'b1; BraTarget = 12'hFFF;
        tick();
        BraTaken = 1'b0;
        check("wrap_pc_pre", 32'(Pc), 32'hFFF);
        wait_valid("wrap", 4);
        check_fields("wrap", mem[12'hFFF]);
        instReady = 1'b1;
        tick();
        instReady = 1'b0;
        ref_cnt = ref_cnt + 1'b1;
        check("wrap_pc",   32'(Pc),        32'd0);
        check("wrap_addr", 32'(ImemAddr),  32'd0);
        check("wrap_ren",  32'(ImemRen),   32'd1);
        check("wrap_cnt",  32'(InstCount), 32'(ref_cnt));

        // HLT accepted together with a branch: the branch cancels the halt
        BraTaken = 1'b1; BraTarget = 12'hF80;
        tick();
        BraTaken = 1'b0;
        wait_valid("hltc", 4);
        check_fields("hltc", mem[12'hF80]);
        instReady = 1'b1; BraTaken = 1'b1; BraTarget = 12'hF00;
        tick();
        instReady = 1'b0; BraTaken = 1'b0;
        ref_cnt = ref_cnt + 1'b1;
        check("hltc_halted", 32'(Halted),    32'd0);
        check("hltc_pc",     32'(Pc),        32'hF00);
        check("hltc_cnt",    32'(InstCount), 32'(ref_cnt));
        check("hltc_ren",    32'(ImemRen),   32'd1);

        // HLT accepted: stop for good, branches ignored
        wait_valid("hlt", 4);
        check_fields("hlt", mem[12'hF00]);
        instReady = 1'b1;
        tick();
        instReady = 1'b0;
        ref_cnt = ref_cnt + 1'b1;
        check("hlt_halted", 32'(Halted),    32'd1);
        check("hlt_valid",  32'(instValid), 32'd0);
        check("hlt_pc",     32'(Pc),        32'hF00);
        check("hlt_cnt",    32'(InstCount), 32'(ref_cnt));
        for (int i = 0; i < 20; i++) begin
            BraTaken = (i % 3 == 0);
            BraTarget = AW'($urandom_range(0, 4095));
            instReady = 1'b1;
            tick();
            check("halt_ren",    32'(ImemRen),   32'd0);
            check("halt_halted", 32'(Halted),    32'd1);
            check("halt_pc",     32'(Pc),        32'hF00);
            check("halt_valid",  32'(instValid), 32'd0);
            check("halt_cnt",    32'(InstCount), 32'(ref_cnt));
        end
        BraTaken = 1'b0;
        instReady = 1'b0;

        // one-cycle reset leaves the halt
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst2_pc",     32'(Pc),        32'd0);
        check("rst2_halted", 32'(Halted),    32'd0);
        check("rst2_cnt",    32'(InstCount), 32'd0);
        check("rst2_valid",  32'(instValid), 32'd0);
        check("rst2_ren",    32'(ImemRen),   32'd1);

        // opcode 0xC at address 7
        BraTaken = 1'b1; BraTarget = 12'h007;
        tick();
        BraTaken = 1'b0;
        wait_valid("op_c", 4);
        check_fields("op_c", mem[7]);
`ifdef INSTR_FETCH_ILLEGAL_OP_EN
        check("illegal_flag", 32'(IllegalOp), 32'd1);
        check("illegal_pc",   32'(IllegalPc), 32'd7);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
